// File: rtl/sweep_pkg.sv
// Shared types and constants for the select-sweep controller.
package sweep_pkg;

  localparam int unsigned NUM_IDX = 16;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Settle counter: counts enabled cycles and flags the last one of each SETTLE-cycle dwell.
module settle_timer #(
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [SETTLE_W-1:0] LastCnt = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LastCnt);

  // Wraps to 0 on expiry so the next index starts a fresh dwell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expired ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sel_sweep_ctrl.sv
// Sweeps SEL1/SEL2 through all 16 combinations with latched data and maps the datapath response.
module sel_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       abcd_in,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic [SEL_W-1:0] SEL1,
  output logic [SEL_W-1:0] SEL2,
  input  logic             out_nume,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic [4:0]       ones_cnt
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_IDX - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       abcd_q, abcd_d;
  logic [15:0]      result_q, result_d;
  logic [4:0]       ones_q, ones_d;
  logic             tmr_clr, tmr_en, tmr_expired;

  settle_timer #(
    .SETTLE   (SETTLE),
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abcd_d   = abcd_q;
    result_d = result_q;
    ones_d   = ones_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          abcd_d   = abcd_in;
          result_d = '0;
          ones_d   = '0;
          idx_d    = '0;
          tmr_clr  = 1'b1;
        end
      end
      StDrive: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d = StSample;
        end
      end
      StSample: begin
        result_d[idx_q] = out_nume;
        ones_d          = ones_q + 5'(out_nume);
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
      end
      StDone: begin
        // SEL returns to index 0 only here, never by wrapping mid-sweep.
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      abcd_q   <= '0;
      result_q <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      abcd_q   <= abcd_d;
      result_q <= result_d;
      ones_q   <= ones_d;
    end
  end

  assign {A, B, C, D} = abcd_q;
  assign SEL1         = idx_q[3:2];
  assign SEL2         = idx_q[1:0];
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign result       = result_q;
  assign ones_cnt     = ones_q;

endmodule
